// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// State encoding and requester ids.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic REQ_M0 = 1'b0;
   localparam logic REQ_M1 = 1'b1;

   function automatic logic misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way winner selection for the arbiter.
// Round-robin or fixed m0 priority.
module dmem_rr_pick
   import dmem_arb_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic winner,
   output logic any
);

   // contention goes to m0 in fixed mode, else to the one not granted last
   always_comb begin
      any    = req0 | req1;
      winner = REQ_M0;
      if (req0 && req1) begin
         winner = (FIXED_PRIO != 0) ? REQ_M0 : ~last_grant;
      end else if (req1) begin
         winner = REQ_M1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter.
// One transaction in flight: IDLE -> ACCESS -> RESP.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_t            state;
   logic              last_grant;
   logic              id_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;

   logic winner;
   logic any;
   logic grant;
   logic mis;
   logic in_access;
   logic in_resp;

   dmem_rr_pick #(
      .FIXED_PRIO(FIXED_PRIO)
   ) u_pick (
      .req0      (m0_req),
      .req1      (m1_req),
      .last_grant(last_grant),
      .winner    (winner),
      .any       (any)
   );

   assign grant     = rst_n & (state == IDLE) & any;
   assign mis       = misaligned(addr_q[1:0]);
   assign in_access = rst_n & (state == ACCESS);
   assign in_resp   = rst_n & (state == RESP);

   // FSM, request capture at the grant edge and response capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= REQ_M1;
         id_q       <= REQ_M0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (grant) begin
                  id_q       <= winner;
                  we_q       <= winner ? m1_we : m0_we;
                  addr_q     <= winner ? m1_addr : m0_addr;
                  wdata_q    <= winner ? m1_wdata : m0_wdata;
                  last_grant <= winner;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               rdata_q <= (!we_q && !mis) ? mem_rdata : '0;
               err_q   <= mis;
               state   <= RESP;
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // grant, memory drive and response steering; all forced low in reset
   always_comb begin
      m0_gnt    = grant & (winner == REQ_M0);
      m1_gnt    = grant & (winner == REQ_M1);
      mem_addr  = in_access ? addr_q : '0;
      mem_wdata = in_access ? wdata_q : '0;
      mem_write = in_access & we_q & ~mis;
      mem_read  = in_access & ~we_q & ~mis;
      m0_rvalid = in_resp & (id_q == REQ_M0);
      m1_rvalid = in_resp & (id_q == REQ_M1);
      m0_rdata  = m0_rvalid ? rdata_q : '0;
      m1_rdata  = m1_rvalid ? rdata_q : '0;
      m0_err    = m0_rvalid & err_q;
      m1_err    = m1_rvalid & err_q;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter.
// Directed table, corner sequences and random vs a transaction model.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

   logic        r_m0_gnt, r_m0_rvalid, r_m0_err;
   logic        r_m1_gnt, r_m1_rvalid, r_m1_err;
   logic [31:0] r_m0_rdata, r_m1_rdata;
   logic [31:0] r_mem_addr, r_mem_wdata, r_mem_rdata;
   logic        r_mem_write, r_mem_read;

   logic        f_m0_gnt, f_m0_rvalid, f_m0_err;
   logic        f_m1_gnt, f_m1_rvalid, f_m1_err;
   logic [31:0] f_m0_rdata, f_m1_rdata;
   logic [31:0] f_mem_addr, f_mem_wdata, f_mem_rdata;
   logic        f_mem_write, f_mem_read;

   int n_checks = 0;
   int n_fail   = 0;
   int wcount   = 0;

   logic [31:0] mem [64];
   logic [31:0] ref_mem [64];
   logic        load_mem = 1'b0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(r_m0_gnt), .m0_rvalid(r_m0_rvalid),
      .m0_rdata(r_m0_rdata), .m0_err(r_m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(r_m1_gnt), .m1_rvalid(r_m1_rvalid),
      .m1_rdata(r_m1_rdata), .m1_err(r_m1_err),
      .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
      .mem_write(r_mem_write), .mem_read(r_mem_read),
      .mem_rdata(r_mem_rdata)
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid),
      .m0_rdata(f_m0_rdata), .m0_err(f_m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid),
      .m1_rdata(f_m1_rdata), .m1_err(f_m1_err),
      .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
      .mem_write(f_mem_write), .mem_read(f_mem_read),
      .mem_rdata(f_mem_rdata)
   );

   assign f_mem_rdata = 32'h0;
   assign r_mem_rdata = mem[r_mem_addr[7:2]];

   function automatic logic [31:0] init_val(input int i);
      return (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0101;
   endfunction

   // memory writes mid-cycle on the falling edge; also counts write cycles
   always @(negedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
      end else if (r_mem_write) begin
         mem[r_mem_addr[7:2]] <= r_mem_wdata;
         wcount <= wcount + 1;
      end
   end

   typedef struct {
      logic        id;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        exp_wr;
      logic        exp_rd;
   } vec_t;

   typedef struct {
      int          due;
      logic        id;
      logic [31:0] rdata;
      logic        err;
   } cmp_t;

   vec_t vt [7];
   cmp_t q [$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic outs_or();
      return |{r_m0_gnt, r_m0_rvalid, r_m0_rdata, r_m0_err,
               r_m1_gnt, r_m1_rvalid, r_m1_rdata, r_m1_err,
               r_mem_addr, r_mem_wdata, r_mem_write, r_mem_read,
               f_m0_gnt, f_m0_rvalid, f_m0_rdata, f_m0_err,
               f_m1_gnt, f_m1_rvalid, f_m1_rdata, f_m1_err,
               f_mem_addr, f_mem_wdata, f_mem_write, f_mem_read};
   endfunction

   task automatic clear_inputs();
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
   endtask

   task automatic drive(input logic id, input logic req, input logic we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (id) begin
         m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
      end else begin
         m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
      end
   endtask

   task automatic reload_mem();
      load_mem = 1'b1;
      @(negedge clk); #1;
      load_mem = 1'b0;
      @(posedge clk); #1;
   endtask

   // called at posedge+1; outputs must be zero even with requests up
   task automatic do_reset();
      rst_n = 1'b0;
      m0_req = 1'b1;
      m1_req = 1'b1;
      @(negedge clk);
      chk("reset_outputs", 32'(outs_or()), 0);
      @(posedge clk); #1;
      clear_inputs();
      rst_n = 1'b1;
   endtask

   // one transaction from IDLE; starts and ends at posedge+1
   task automatic run_txn(input vec_t v, input int n);
      int wc0;
      string tag;
      tag = $sformatf("vec%0d", n);
      wc0 = wcount;
      drive(v.id, 1'b1, v.we, v.addr, v.wdata);
      @(negedge clk);
      chk({tag, "_gnt"}, 32'(v.id ? r_m1_gnt : r_m0_gnt), 1);
      chk({tag, "_gnt_other"}, 32'(v.id ? r_m0_gnt : r_m1_gnt), 0);
      @(posedge clk); #1;
      clear_inputs();
      @(negedge clk);
      chk({tag, "_mem_write"}, 32'(r_mem_write), 32'(v.exp_wr));
      chk({tag, "_mem_read"}, 32'(r_mem_read), 32'(v.exp_rd));
      if (v.exp_wr || v.exp_rd) chk({tag, "_mem_addr"}, r_mem_addr, v.addr);
      chk({tag, "_early_rvalid"}, 32'(r_m0_rvalid | r_m1_rvalid), 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_rvalid"}, 32'(v.id ? r_m1_rvalid : r_m0_rvalid), 1);
      chk({tag, "_rvalid_other"}, 32'(v.id ? r_m0_rvalid : r_m1_rvalid), 0);
      chk({tag, "_rdata"}, v.id ? r_m1_rdata : r_m0_rdata, v.exp_rdata);
      chk({tag, "_err"}, 32'(v.id ? r_m1_err : r_m0_err), 32'(v.exp_err));
      @(posedge clk); #1;
      chk({tag, "_write_count"}, 32'(wcount - wc0), 32'(v.exp_wr));
   endtask

   logic        pend [2];
   logic        pwe [2];
   logic [31:0] paddr [2];
   logic [31:0] pwdata [2];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      int          busy;
      int          wr_due;
      int          rd_due;
      logic        last;
      logic        w;
      logic        g0, g1, ev0, ev1, mis;
      logic [31:0] ed0, ed1, rd;
      logic        ee0, ee1;
      logic [5:0]  idx, wi;
      logic [1:0]  lsb;

      vt[0] = '{1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
      vt[1] = '{1'b1, 1'b1, 32'h22, 32'h12345678, 32'h0, 1'b1, 1'b0, 1'b0};
      vt[2] = '{1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b1, 1'b0};
      vt[3] = '{1'b1, 1'b0, 32'h40, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1};
      vt[4] = '{1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0};
      vt[5] = '{1'b0, 1'b0, 32'h40, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1};
      vt[6] = '{1'b0, 1'b1, 32'h41, 32'h55, 32'h0, 1'b1, 1'b0, 1'b0};

      rst_n = 1'b0;
      clear_inputs();
      @(posedge clk); #1;
      reload_mem();
      do_reset();

      for (int i = 0; i < 7; i++) run_txn(vt[i], i);

      // both requesters hold requests: alternation vs m1 starvation
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk($sformatf("rr_gnt0_c%0d", c), 32'(r_m0_gnt), 32'(c % 6 == 0));
         chk($sformatf("rr_gnt1_c%0d", c), 32'(r_m1_gnt), 32'(c % 6 == 3));
         chk($sformatf("fp_gnt0_c%0d", c), 32'(f_m0_gnt), 32'(c % 3 == 0));
         chk($sformatf("fp_gnt1_c%0d", c), 32'(f_m1_gnt), 0);
         @(posedge clk); #1;
      end
      clear_inputs();
      repeat (3) begin @(posedge clk); #1; end

      // reset during ACCESS abandons the load
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      chk("abort_gnt", 32'(r_m0_gnt), 1);
      @(posedge clk); #1;
      clear_inputs();
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_outputs", 32'(outs_or()), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("abort_no_rvalid", 32'(r_m0_rvalid), 0);
         @(posedge clk); #1;
      end
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
      @(negedge clk);
      chk("abort_next_gnt0", 32'(r_m0_gnt), 1);
      chk("abort_next_gnt1", 32'(r_m1_gnt), 0);
      @(posedge clk); #1;
      clear_inputs();
      repeat (3) begin @(posedge clk); #1; end

      // random traffic against a transaction-level model
      do_reset();
      reload_mem();
      for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
      busy = 0; last = 1'b1; wr_due = -1; rd_due = -1;
      pend[0] = 0; pend[1] = 0;
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < 2; k++) begin
            if (!pend[k] && $urandom_range(9) < 4) begin
               pend[k] = 1'b1;
               pwe[k] = 1'($urandom_range(1));
               idx = 6'($urandom_range(63));
               lsb = ($urandom_range(4) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
               paddr[k] = {24'h0, idx, lsb};
               pwdata[k] = $urandom;
            end
            drive(1'(k), pend[k], pwe[k], paddr[k], pwdata[k]);
         end
         @(negedge clk);
         g0 = 0; g1 = 0; w = 0;
         if (busy == 0 && (pend[0] || pend[1])) begin
            w = (pend[0] && pend[1]) ? ~last : pend[1];
            g0 = ~w; g1 = w;
         end
         chk("rnd_gnt0", 32'(r_m0_gnt), 32'(g0));
         chk("rnd_gnt1", 32'(r_m1_gnt), 32'(g1));
         ev0 = 0; ev1 = 0; ed0 = 0; ed1 = 0; ee0 = 0; ee1 = 0;
         if (q.size() > 0 && q[0].due == c) begin
            if (q[0].id) begin ev1 = 1; ed1 = q[0].rdata; ee1 = q[0].err; end
            else begin ev0 = 1; ed0 = q[0].rdata; ee0 = q[0].err; end
            void'(q.pop_front());
         end
         chk("rnd_rvalid0", 32'(r_m0_rvalid), 32'(ev0));
         chk("rnd_rvalid1", 32'(r_m1_rvalid), 32'(ev1));
         chk("rnd_rdata0", r_m0_rdata, ed0);
         chk("rnd_rdata1", r_m1_rdata, ed1);
         chk("rnd_err0", 32'(r_m0_err), 32'(ee0));
         chk("rnd_err1", 32'(r_m1_err), 32'(ee1));
         chk("rnd_mem_write", 32'(r_mem_write), 32'(wr_due == c));
         chk("rnd_mem_read", 32'(r_mem_read), 32'(rd_due == c));
         if (g0 || g1) begin
            mis = paddr[w][1:0] != 2'b00;
            wi = paddr[w][7:2];
            rd = 32'h0;
            if (pwe[w] && !mis) begin
               ref_mem[wi] = pwdata[w];
               wr_due = c + 1;
            end
            if (!pwe[w] && !mis) begin
               rd = ref_mem[wi];
               rd_due = c + 1;
            end
            q.push_back('{c + 2, w, rd, mis});
            last = w;
            busy = 2;
            pend[w] = 1'b0;
         end else if (busy > 0) begin
            busy--;
         end
         for (int k = 0; k < 2; k++)
            if (pend[k] && $urandom_range(19) == 0) pend[k] = 1'b0;
         @(posedge clk); #1;
      end
      clear_inputs();
      repeat (4) begin @(posedge clk); #1; end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
